// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SDRAM controller among
// NUM_PORTS requesters. Only one transaction is outstanding at a time.
// The command is held until the controller responds, then dropped.

// Per-port response strobes, registered so that every port output is a flop.
module sdram_port_arbiter_lane #(
  parameter int IDX = 0,
  parameter int PW  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [PW-1:0] gnt_d,
  input  logic          accept_en,
  input  logic          wdone_en,
  input  logic          rvalid_en,
  output logic          accept,
  output logic          write_done,
  output logic          read_valid
);
  logic hit;
  assign hit = (gnt_d == PW'(IDX));

  // a strobe reaches this port only when the port owns the transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accept     <= 1'b0;
      write_done <= 1'b0;
      read_valid <= 1'b0;
    end else begin
      accept     <= hit & accept_en;
      write_done <= hit & wdone_en;
      read_valid <= hit & rvalid_en;
    end
  end
endmodule

module sdram_port_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int ADDR_WIDTH        = 22,
  parameter int READ_BURST_LENGTH = 1,
  parameter int RESET_HOLDOFF     = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS-1:0]            port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address,
  input  logic [NUM_PORTS*16-1:0]         port_wdata,
  output logic [NUM_PORTS-1:0]            port_accept,
  output logic [NUM_PORTS-1:0]            port_write_done,
  output logic [NUM_PORTS-1:0]            port_read_valid,
  output logic [15:0]                     port_read_data,
  output logic [1:0]                      ctrl_command,
  output logic [ADDR_WIDTH-1:0]           ctrl_address,
  output logic [15:0]                     ctrl_write_data,
  input  logic [15:0]                     ctrl_read_data,
  input  logic                            ctrl_read_valid,
  input  logic                            ctrl_write_done
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int HW = $clog2(RESET_HOLDOFF + 2);
  localparam int BW = $clog2(READ_BURST_LENGTH + 2);

  typedef enum logic [1:0] {S_HOLDOFF, S_IDLE, S_ISSUE, S_READ_BURST} state_t;

  state_t          state, state_d;
  logic [HW-1:0]   cnt, cnt_d;
  logic [PW-1:0]   rr, rr_d, gnt, gnt_d, sel;
  logic            is_wr, is_wr_d, req_any;
  logic [BW-1:0]   beats, beats_d;
  logic [1:0]      cmd_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]     wdata_d, rdata_d;
  logic            accept_en, wdone_en, rvalid_en;

  // first requester after the last grant, wrapping modulo NUM_PORTS
  always_comb begin
    int p;
    p       = 0;
    req_any = 1'b0;
    sel     = rr;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = int'(rr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!req_any && port_req[p]) begin
        req_any = 1'b1;
        sel     = PW'(p);
      end
    end
  end

  // next state and next register values for every output
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    rr_d      = rr;
    gnt_d     = gnt;
    is_wr_d   = is_wr;
    beats_d   = beats;
    cmd_d     = ctrl_command;
    addr_d    = ctrl_address;
    wdata_d   = ctrl_write_data;
    rdata_d   = port_read_data;
    accept_en = 1'b0;
    wdone_en  = 1'b0;
    rvalid_en = 1'b0;
    case (state)
      S_HOLDOFF: begin
        // controller has no reset; let whatever it had in flight drain
        cmd_d = 2'd0;
        if (cnt == '0) state_d = S_IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      S_IDLE: begin
        cmd_d = 2'd0;
        if (req_any) begin
          gnt_d     = sel;
          rr_d      = sel;
          is_wr_d   = port_write[sel];
          addr_d    = port_address[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d   = port_wdata[int'(sel)*16 +: 16];
          cmd_d     = port_write[sel] ? 2'd1 : 2'd2;
          accept_en = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // hold the command until the controller answers, however long
        if (is_wr) begin
          if (ctrl_write_done) begin
            cmd_d    = 2'd0;
            wdone_en = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (ctrl_read_valid) begin
          cmd_d     = 2'd0;
          rdata_d   = ctrl_read_data;
          rvalid_en = 1'b1;
          if (READ_BURST_LENGTH == 1) begin
            state_d = S_IDLE;
          end else begin
            beats_d = BW'(READ_BURST_LENGTH - 1);
            state_d = S_READ_BURST;
          end
        end
      end
      S_READ_BURST: begin
        // beat count is the only exit; gaps in valid just wait
        if (ctrl_read_valid) begin
          rdata_d   = ctrl_read_data;
          rvalid_en = 1'b1;
          beats_d   = beats - 1'b1;
          if (beats == BW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_HOLDOFF;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_HOLDOFF;
      cnt             <= HW'(RESET_HOLDOFF);
      rr              <= PW'(NUM_PORTS - 1);
      gnt             <= '0;
      is_wr           <= 1'b0;
      beats           <= '0;
      ctrl_command    <= 2'd0;
      ctrl_address    <= '0;
      ctrl_write_data <= '0;
      port_read_data  <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      rr              <= rr_d;
      gnt             <= gnt_d;
      is_wr           <= is_wr_d;
      beats           <= beats_d;
      ctrl_command    <= cmd_d;
      ctrl_address    <= addr_d;
      ctrl_write_data <= wdata_d;
      port_read_data  <= rdata_d;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    sdram_port_arbiter_lane #(.IDX(i), .PW(PW)) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .gnt_d      (gnt_d),
      .accept_en  (accept_en),
      .wdone_en   (wdone_en),
      .rvalid_en  (rvalid_en),
      .accept     (port_accept[i]),
      .write_done (port_write_done[i]),
      .read_valid (port_read_valid[i])
    );
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: holdoff, read bursts with gaps,
// writes, round-robin fairness, long refresh stall and reset mid-burst.
module tb_sdram_port_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 22;
  localparam int RBL = 4;
  localparam int RHO = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     port_req, port_write;
  logic [NP*AW-1:0]  port_address;
  logic [NP*16-1:0]  port_wdata;
  logic [NP-1:0]     port_accept, port_write_done, port_read_valid;
  logic [15:0]       port_read_data;
  logic [1:0]        ctrl_command;
  logic [AW-1:0]     ctrl_address;
  logic [15:0]       ctrl_write_data;
  logic [15:0]       ctrl_read_data;
  logic              ctrl_read_valid, ctrl_write_done;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .READ_BURST_LENGTH(RBL), .RESET_HOLDOFF(RHO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .port_req(port_req), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata),
    .port_accept(port_accept), .port_write_done(port_write_done),
    .port_read_valid(port_read_valid), .port_read_data(port_read_data),
    .ctrl_command(ctrl_command), .ctrl_address(ctrl_address),
    .ctrl_write_data(ctrl_write_data), .ctrl_read_data(ctrl_read_data),
    .ctrl_read_valid(ctrl_read_valid), .ctrl_write_done(ctrl_write_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic wr, input logic [AW-1:0] a, input logic [15:0] d);
    port_write[p]           = wr;
    port_address[p*AW +: AW] = a;
    port_wdata[p*16 +: 16]   = d;
  endtask

  function automatic logic [127:0] all_outs();
    return {port_accept, port_write_done, port_read_valid, port_read_data,
            ctrl_command, ctrl_address, ctrl_write_data};
  endfunction

  initial begin
    int bad, wd;
    logic [15:0] beat;
    reset_n = 1'b0;
    port_req = '0; port_write = '0; port_address = '0; port_wdata = '0;
    ctrl_read_data = '0; ctrl_read_valid = 1'b0; ctrl_write_done = 1'b0;

    // reset, port0 read requested from the start
    set_port(0, 1'b0, 22'h000123, 16'h0);
    port_req = 4'b0001;
    #3;
    chk("reset_outs_early", all_outs(), 128'h0);
    tick(); tick();
    chk("reset_outs", all_outs(), 128'h0);
    reset_n = 1'b1;
    for (int i = 0; i < RHO; i++) begin
      tick();
      chk("holdoff_quiet", {ctrl_command, port_accept}, 6'h0);
    end
    tick();
    chk("holdoff_exit_quiet", {ctrl_command, port_accept}, 6'h0);
    tick();
    chk("rd0_cmd", ctrl_command, 2'd2);
    chk("rd0_addr", ctrl_address, 22'h000123);
    chk("rd0_accept", port_accept, 4'b0001);
    port_req = '0;
    ctrl_read_valid = 1'b1;
    for (int b = 1; b <= RBL; b++) begin
      beat = 16'hA000 + 16'(b);
      ctrl_read_data = beat;
      tick();
      chk("rd0_rvalid", {port_accept, port_read_valid, port_read_data, ctrl_command},
          {4'b0000, 4'b0001, beat, 2'd0});
    end
    ctrl_read_valid = 1'b0;
    tick();
    chk("rd0_done", port_read_valid, 4'b0000);

    // port1 write, done arrives 5 cycles later
    set_port(1, 1'b1, 22'h0ABCDE, 16'hBEEF);
    port_req = 4'b0010;
    tick();
    chk("wr1_accept", {port_accept, ctrl_command, ctrl_address, ctrl_write_data},
        {4'b0010, 2'd1, 22'h0ABCDE, 16'hBEEF});
    port_req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wr1_hold", {port_accept, port_write_done, ctrl_command, ctrl_address, ctrl_write_data},
          {4'b0000, 4'b0000, 2'd1, 22'h0ABCDE, 16'hBEEF});
    end
    ctrl_write_done = 1'b1;
    tick();
    chk("wr1_done", {port_write_done, ctrl_command, ctrl_write_data}, {4'b0010, 2'd0, 16'hBEEF});
    ctrl_write_done = 1'b0;
    tick();
    chk("wr1_done_pulse", port_write_done, 4'b0000);

    // port2 read burst with a gap after beat 2; port3 waits for the burst
    set_port(2, 1'b0, 22'h200000, 16'h0);
    set_port(3, 1'b1, 22'h333333, 16'h3333);
    port_req = 4'b0100;
    tick();
    chk("rd2_accept", {port_accept, ctrl_command, ctrl_address}, {4'b0100, 2'd2, 22'h200000});
    port_req = '0;
    ctrl_read_valid = 1'b1; ctrl_read_data = 16'h1111;
    tick();
    chk("rd2_b1", {port_read_valid, port_read_data, ctrl_command}, {4'b0100, 16'h1111, 2'd0});
    ctrl_read_data = 16'h2222;
    tick();
    chk("rd2_b2", {port_read_valid, port_read_data}, {4'b0100, 16'h2222});
    port_req = 4'b1000;
    ctrl_read_valid = 1'b0;
    tick();
    chk("rd2_gap", {port_read_valid, port_accept}, {4'b0000, 4'b0000});
    ctrl_read_valid = 1'b1; ctrl_read_data = 16'h3333;
    tick();
    chk("rd2_b3", {port_read_valid, port_read_data, port_accept}, {4'b0100, 16'h3333, 4'b0000});
    ctrl_read_data = 16'h4444;
    tick();
    chk("rd2_b4", {port_read_valid, port_read_data, port_accept}, {4'b0100, 16'h4444, 4'b0000});
    ctrl_read_valid = 1'b0;
    tick();
    chk("rd2_then_p3", {port_read_valid, port_accept, ctrl_command}, {4'b0000, 4'b1000, 2'd1});
    port_req = '0;
    ctrl_write_done = 1'b1;
    tick();
    chk("wr3_done", {port_write_done, ctrl_command}, {4'b1000, 2'd0});

    // all ports request continuously, controller answers at once
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p + 16), 16'(p + 16));
    port_req = 4'b1111;
    for (int k = 0; k < 2 * NP; k++) begin
      tick();
      chk("rr_accept", port_accept, 4'b0001 << (k % NP));
      tick();
      chk("rr_wdone", port_write_done, 4'b0001 << (k % NP));
    end
    port_req = '0;
    ctrl_write_done = 1'b0;

    // refresh stall: controller holds off acceptance for 200 cycles
    set_port(0, 1'b1, 22'h3FFFFF, 16'hFFFF);
    port_req = 4'b0001;
    tick();
    chk("ref_accept", {port_accept, ctrl_command}, {4'b0001, 2'd1});
    port_req = '0;
    bad = 0; wd = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ({ctrl_command, ctrl_address, ctrl_write_data} !== {2'd1, 22'h3FFFFF, 16'hFFFF}) bad++;
      if (port_write_done !== 4'b0000) wd++;
    end
    chk("ref_hold_stable", 128'(bad), 128'h0);
    chk("ref_no_early_done", 128'(wd), 128'h0);
    ctrl_write_done = 1'b1;
    tick();
    chk("ref_done", {port_write_done, ctrl_command}, {4'b0001, 2'd0});
    tick();
    chk("stray_done_idle", port_write_done, 4'b0000);
    ctrl_write_done = 1'b0;

    // reset in the middle of a read burst, stray read_valid during holdoff
    set_port(1, 1'b0, 22'h111111, 16'h0);
    port_req = 4'b0010;
    tick();
    chk("rd1_accept", {port_accept, ctrl_command}, {4'b0010, 2'd2});
    port_req = '0;
    ctrl_read_valid = 1'b1; ctrl_read_data = 16'h5A5A;
    tick();
    chk("rd1_b1", {port_read_valid, port_read_data}, {4'b0010, 16'h5A5A});
    #2 reset_n = 1'b0;
    #1 chk("midreset_async", all_outs(), 128'h0);
    tick();
    chk("midreset_hold", all_outs(), 128'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("holdoff_stray", {port_read_valid, ctrl_command}, 6'h0);
    end
    ctrl_read_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-port SDRAM controller (`command`, `data_address`, `data_write`, `data_read`, `data_read_valid`, `data_write_done`) among NUM_PORTS client requesters.
- Round-robin arbitration with per-port request/accept, write-done and read-data handshakes.
- Holds the controller command until the controller acknowledges it, then drops it so the controller cannot re-issue the transaction.
- Sits between the client blocks (video, CPU, DMA) and the SDRAM controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- ADDR_WIDTH, 22, word address width, matching the controller's `data_address`.
- READ_BURST_LENGTH, 1, beats per read. Must equal the controller's setting.
- RESET_HOLDOFF, 64, cycles after reset release before the first command is issued. Must exceed the controller's longest in-flight operation.

Ports:
- clk  in  1  system clock, shared with the controller.
- reset_n  in  1  asynchronous active-low reset.
- port_req  in  NUM_PORTS  per-port request valid.
- port_write  in  NUM_PORTS  per-port 1=write, 0=read.
- port_address  in  NUM_PORTS*ADDR_WIDTH  packed per-port addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- port_wdata  in  NUM_PORTS*16  packed per-port write data.
- port_accept  out  NUM_PORTS  one-cycle pulse: request latched, requester may change its inputs next cycle.
- port_write_done  out  NUM_PORTS  one-cycle pulse: write committed.
- port_read_valid  out  NUM_PORTS  high for each returned read beat.
- port_read_data  out  16  shared read data bus, qualified by port_read_valid.
- ctrl_command  out  2  to controller: 0 idle, 1 write, 2 read.
- ctrl_address  out  ADDR_WIDTH  to controller `data_address`.
- ctrl_write_data  out  16  to controller `data_write`.
- ctrl_read_data  in  16  from controller `data_read`.
- ctrl_read_valid  in  1  from controller `data_read_valid`.
- ctrl_write_done  in  1  from controller `data_write_done`.

Behaviour:
- Reset (async assert): state=HOLDOFF, holdoff counter=RESET_HOLDOFF, ctrl_command=0, ctrl_address=0, ctrl_write_data=0, all port_* outputs 0, rr pointer=NUM_PORTS-1.
- All outputs are registered.
- HOLDOFF: decrement the counter each cycle. At 0 -> IDLE. port_req is ignored and controller responses are discarded. The controller has no reset, so any operation it had in flight drains during this window.
- IDLE: if any port_req, grant the first requesting port searching from rr_pointer+1 upward with wrap modulo NUM_PORTS. On that edge:
  - latch port_address and port_wdata of the granted port into ctrl_address and ctrl_write_data;
  - set ctrl_command = port_write ? 1 : 2;
  - pulse port_accept[g];
  - set rr_pointer=g;
  - go to ISSUE.
- IDLE with no request: ctrl_command=0.
- ISSUE: ctrl_command, ctrl_address and ctrl_write_data are held constant.
  - Write: on the first cycle ctrl_write_done=1, set ctrl_command=0, pulse port_write_done[g], go to IDLE.
  - Read: on each cycle ctrl_read_valid=1, register ctrl_read_data into port_read_data and assert port_read_valid[g] the next cycle (1-cycle latency). On the first beat set ctrl_command=0. If READ_BURST_LENGTH==1 go to IDLE, else load beats_left=READ_BURST_LENGTH-1 and go to READ_BURST.
  - The hold in ISSUE has no bound: a controller refresh delays acceptance arbitrarily.
- READ_BURST: forward each valid beat as above and decrement beats_left. At beats_left==1 with valid -> IDLE.
  - If ctrl_read_valid drops before all beats arrive, stay in READ_BURST.
  - Beat count is the only exit condition.
- Back-to-back: the next grant is possible on the cycle after returning to IDLE. A command asserted while the controller is still precharging is simply held until the controller's idle state samples it. There are no gaps beyond one arbiter cycle.
- Only one transaction is outstanding at a time. port_accept/port_write_done/port_read_valid are never asserted for a non-granted port.
- Responses arriving in IDLE or HOLDOFF (ctrl_read_valid or ctrl_write_done with no outstanding op) are ignored. Nothing is forwarded.
- A requester dropping port_req after grant has no effect: the request was latched at accept.
- Requester holds port_req high across accept: this is treated as a new request. It competes again in round-robin order, after the other ports.
- Reset mid-operation: everything returns to HOLDOFF immediately. The in-flight transaction is lost and no done/valid is reported for it.
- Controller constraints: WRITE_BURST=0 or READ_BURST_LENGTH=1. Writes are single-beat.

Test Plan:
- Reset then port0 read 0x000123 at cycle 0 -> no ctrl_command until RESET_HOLDOFF cycles elapse; then ctrl_command=2, ctrl_address=0x000123, port_accept[0] one pulse.
- Port1 write 0x0ABCDE data 0xBEEF; controller model raises write_done 5 cycles later -> ctrl_command returns to 0 on the next edge; port_write_done[1] one pulse; ctrl_write_data stable 0xBEEF throughout.
- All 4 ports request continuously -> grants 0,1,2,3,0,... each port accepted exactly once per 4 transactions.
- READ_BURST_LENGTH=4; model returns 0x1111..0x4444 with a 1-cycle gap after beat 2 -> port_read_valid[2] high for exactly 4 cycles, data in order, state returns to IDLE only after beat 4.
- Model delays acceptance 200 cycles (refresh) -> ctrl_command stays 1 with constant address/data; exactly one port_write_done.
- Assert reset_n low mid-read burst; model emits a stray read_valid during holdoff -> no port_read_valid; all outputs 0 during reset.
